// File: rtl/fifo_tx_defs.sv
// Shared definitions for the FIFO serial transmitter: FSM state encoding
// and the default word width / bit period.
package fifo_tx_defs;

  // Word width of the upstream FIFO.
  localparam int DEFAULT_WIDTH        = 20;

  // Clock cycles spent on each serial bit.
  localparam int DEFAULT_CLKS_PER_BIT = 4;

  // Transmitter states. The numeric values are fixed so that the state can
  // be recognised on a probe or in a waveform without a decoder.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } tx_state_t;

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and raises tick in the last
// cycle of every bit period. clear restarts the period from zero.
module baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Period counter; wraps after the last cycle and restarts on clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// FIFO-fed asynchronous serial transmitter. Pops one word from the FIFO,
// then sends start bit, WIDTH data bits LSB first, and a stop bit on tx.
module fifo_serial_tx
  import fifo_tx_defs::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             empty,
  input  logic [WIDTH-1:0] data_in,
  output logic             read,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int            BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_t        state;
  tx_state_t        state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [BW-1:0]    bit_idx;
  logic [BW-1:0]    bit_idx_next;
  logic             tx_next;
  logic             tick;
  logic             baud_clear;

  // Restart the bit period whenever the FSM changes state, so every state
  // begins with a full CLKS_PER_BIT window.
  assign baud_clear = (state_next != state);

  baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear),
    .tick  (tick)
  );

  // State, shift register, bit index and the registered serial line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      tx        <= 1'b1;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_idx   <= bit_idx_next;
      tx        <= tx_next;
    end
  end

  // Next-state logic; tx_next is the line level for the cycle after the
  // edge, so the line only moves on bit boundaries.
  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx;
    tx_next      = tx;

    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (enable && !empty) begin
          state_next = POP;
        end
      end

      POP: begin
        state_next = LOAD;
      end

      LOAD: begin
        shift_next = data_in;
        state_next = START;
        tx_next    = 1'b0;
      end

      START: begin
        if (tick) begin
          state_next   = DATA;
          bit_idx_next = '0;
          tx_next      = shift_reg[0];
        end
      end

      DATA: begin
        if (tick) begin
          shift_next = shift_reg >> 1;
          if (bit_idx == LAST_BIT) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
            tx_next      = shift_reg[1];
          end
        end
      end

      STOP: begin
        tx_next = 1'b1;
        if (tick) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign read       = (state == POP);
  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && tick;

endmodule
